// File: rtl/icache_2way.sv
// Blocking 2-way set-associative instruction cache between the fetch stages and the memory bus.
// A hit answers the cycle after acceptance. A miss stalls the front end and refills one line by burst read.
module icache_2way #(
    parameter int INDEX_W  = 7,
    parameter int OFFSET_W = 4,
    parameter int TAG_W    = 32 - INDEX_W - OFFSET_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] addr,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] inst,
    input  logic        cancel,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
);
    localparam int SETS   = 1 << INDEX_W;
    localparam int WORD_W = OFFSET_W - 2;
    localparam int WORDS  = 1 << WORD_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, RESP} state_t;

    state_t                       state;
    logic [31:2]                  req_addr;
    logic [TAG_W-1:0]             req_tag;
    logic [INDEX_W-1:0]           req_index;
    logic [WORD_W-1:0]            req_word;

    logic [SETS-1:0]              valid0, valid1, lru;
    logic [TAG_W-1:0]             tag0 [SETS];
    logic [TAG_W-1:0]             tag1 [SETS];
    logic [WORDS-1:0][31:0]       line0 [SETS];
    logic [WORDS-1:0][31:0]       line1 [SETS];

    logic [WORDS-1:0][31:0]       line_buf, fill_line, hit_line;
    logic [WORD_W-1:0]            cnt;
    logic                         victim, cancelled;
    logic                         hit0, hit1, hit, accept;
    logic [31:0]                  inst_q;
    logic                         unused_lsb;

    assign unused_lsb = ^addr[1:0];

    assign req_tag   = req_addr[31:32-TAG_W];
    assign req_index = req_addr[OFFSET_W +: INDEX_W];
    assign req_word  = req_addr[2 +: WORD_W];

    assign hit0     = valid0[req_index] && (tag0[req_index] == req_tag);
    assign hit1     = valid1[req_index] && (tag1[req_index] == req_tag);
    assign hit      = hit0 || hit1;
    assign hit_line = hit1 ? line1[req_index] : line0[req_index];

    always_comb begin
        fill_line      = line_buf;
        fill_line[cnt] = ret_data;
    end

    always_comb begin
        addr_ok = 1'b0;
        data_ok = 1'b0;
        case (state)
            IDLE:    addr_ok = 1'b1;
            LOOKUP: begin
                addr_ok = hit || cancel;
                data_ok = hit && !cancel;
            end
            RESP:    data_ok = !cancelled && !cancel;
            default: ;
        endcase
    end

    assign accept = valid && addr_ok;
    assign rd_req = (state == MISS);

    always_comb begin
        inst = inst_q;
        if (data_ok)
            inst = (state == RESP) ? line_buf[req_word] : hit_line[req_word];
    end

    // Control: FSM, valid/LRU state, registered bus address and output hold register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            valid0    <= '0;
            valid1    <= '0;
            lru       <= '0;
            cnt       <= '0;
            victim    <= 1'b0;
            cancelled <= 1'b0;
            rd_addr   <= '0;
            inst_q    <= '0;
        end else begin
            inst_q <= inst;
            case (state)
                IDLE: if (valid) state <= LOOKUP;
                LOOKUP: begin
                    if (hit || cancel) begin
                        if (hit && !cancel) lru[req_index] <= hit1;
                        state <= valid ? LOOKUP : IDLE;
                    end else begin
                        // Invalid way first (way0 preferred), otherwise the LRU way
                        if (!valid0[req_index])      victim <= 1'b0;
                        else if (!valid1[req_index]) victim <= 1'b1;
                        else                         victim <= !lru[req_index];
                        rd_addr   <= {req_tag, req_index, {OFFSET_W{1'b0}}};
                        cancelled <= 1'b0;
                        state     <= MISS;
                    end
                end
                MISS: begin
                    if (rd_rdy) begin
                        cnt       <= '0;
                        cancelled <= cancel;
                        state     <= REFILL;
                    end else if (cancel) begin
                        state <= IDLE;
                    end
                end
                REFILL: begin
                    if (cancel) cancelled <= 1'b1;
                    if (ret_valid) begin
                        cnt <= cnt + 1'b1;
                        if (ret_last) begin
                            if (victim) valid1[req_index] <= 1'b1;
                            else        valid0[req_index] <= 1'b1;
                            lru[req_index] <= victim;
                            state          <= RESP;
                        end
                    end
                end
                RESP: begin
                    cancelled <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data: request register, refill line buffer and tag/data arrays
    always_ff @(posedge clk) begin
        if (accept) req_addr <= addr[31:2];
        if (state == REFILL && ret_valid) begin
            line_buf[cnt] <= ret_data;
            if (ret_last) begin
                if (victim) begin
                    tag1[req_index]  <= req_tag;
                    line1[req_index] <= fill_line;
                end else begin
                    tag0[req_index]  <= req_tag;
                    line0[req_index] <= fill_line;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state == LOOKUP) assert (!(hit0 && hit1));
        if (!rst && state == REFILL && ret_valid && ret_last) assert (cnt == WORD_W'(WORDS - 1));
    end

endmodule
